hwrot_cmd_sequencer: RTL and testbench

//  Host-side command sequencer directly upstream of the HW-RoT crypto hub.

---
 rtl/hwrot_cmd_sequencer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_hwrot_cmd_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwrot_cmd_sequencer.sv
// hwrot_cmd_sequencer: host command sequencer driving the HW-RoT crypto hub bus.
// Optional statistics counters are built only when HWROT_SEQ_STATS_EN is defined.

module hwrot_cmd_sequencer #(
   parameter int unsigned          WR_HOLD     = 1,
   parameter int unsigned          RD_LAT      = 2,
   parameter int unsigned          TIMEOUT_W   = 20,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 20'hFFFFF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [1:0]  i_cmd_type,
   input  logic [31:0] i_cmd_module,
   input  logic [31:0] i_cmd_ctrl,
   input  logic [63:0] i_cmd_add,
   input  logic [63:0] i_cmd_data,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [63:0] o_rsp_data,
   output logic [1:0]  o_rsp_status,
   output logic [63:0] o_hw_data_in,
   output logic [63:0] o_hw_add,
   output logic [63:0] o_hw_control,
   input  logic [63:0] i_hw_data_out,
   input  logic [1:0]  i_hw_end_op,
   output logic        o_busy,
   output logic [15:0] o_stat_cmds,
   output logic [15:0] o_stat_tmo
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT_RD = 3'd2,
      S_POLL    = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   localparam logic [1:0] CMD_WRITE   = 2'b00;
   localparam logic [1:0] CMD_READ    = 2'b01;
   localparam logic [1:0] CMD_WAIT    = 2'b10;
   localparam logic [1:0] CMD_ILLEGAL = 2'b11;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_NOMOD   = 2'b10;
   localparam logic [1:0] ST_ILLEGAL = 2'b11;

   localparam logic [1:0] END_DONE  = 2'b01;
   localparam logic [1:0] END_NOMOD = 2'b11;

   localparam logic [3:0] WR_LAST = 4'(WR_HOLD - 1);
   localparam logic [3:0] RD_LAST = 4'(RD_LAT - 1);

   state_t                 state_r, state_s;
   logic [1:0]             type_r, type_s;
   logic [3:0]             lat_cnt_r, lat_cnt_s;
   logic [TIMEOUT_W-1:0]   poll_cnt_r, poll_cnt_s, poll_inc_s;
   logic                   poll_done_s;
   logic                   accept_s;
   logic [63:0]            rsp_data_r, rsp_data_s;
   logic [1:0]             rsp_status_r, rsp_status_s;
   logic [63:0]            hw_data_in_r, hw_data_in_s;
   logic [63:0]            hw_add_r, hw_add_s;
   logic [63:0]            hw_control_r, hw_control_s;
   logic                   cmd_ready_r, rsp_valid_r, busy_r;

   assign accept_s    = i_cmd_valid && cmd_ready_r && (state_r == S_IDLE);
   assign poll_inc_s  = poll_cnt_r + TIMEOUT_W'(1);
   assign poll_done_s = (poll_inc_s == TIMEOUT_MAX);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               state_s = (i_cmd_type == CMD_ILLEGAL) ? S_RESP : S_ISSUE;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ISSUE: begin
            case (type_r)
               CMD_WRITE: state_s = (lat_cnt_r == WR_LAST) ? S_RESP : S_ISSUE;
               CMD_READ:  state_s = S_WAIT_RD;
               CMD_WAIT:  state_s = S_POLL;
               default:   state_s = S_RESP;
            endcase
         end
         S_WAIT_RD: begin
            if (lat_cnt_r == RD_LAST) begin
               state_s = S_RESP;
            end else begin
               state_s = S_WAIT_RD;
            end
         end
         S_POLL: begin
            if ((i_hw_end_op == END_DONE) || (i_hw_end_op == END_NOMOD) || poll_done_s) begin
               state_s = S_RESP;
            end else begin
               state_s = S_POLL;
            end
         end
         S_RESP: begin
            if (i_rsp_ready) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_RESP;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // Next values of datapath and bus registers
   always_comb begin
      type_s       = type_r;
      lat_cnt_s    = lat_cnt_r;
      poll_cnt_s   = poll_cnt_r;
      rsp_data_s   = rsp_data_r;
      rsp_status_s = rsp_status_r;
      hw_data_in_s = hw_data_in_r;
      hw_add_s     = hw_add_r;
      hw_control_s = hw_control_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               type_s     = i_cmd_type;
               lat_cnt_s  = 4'd0;
               poll_cnt_s = '0;
               if (i_cmd_type == CMD_ILLEGAL) begin
                  rsp_data_s   = 64'h0;
                  rsp_status_s = ST_ILLEGAL;
               end else begin
                  // Bus is loaded at acceptance so it is visible during ISSUE
                  hw_data_in_s = i_cmd_data;
                  hw_add_s     = i_cmd_add;
                  hw_control_s = {i_cmd_module, i_cmd_ctrl};
               end
            end else begin
               type_s = type_r;
            end
         end
         S_ISSUE: begin
            if (type_r == CMD_WRITE) begin
               if (lat_cnt_r == WR_LAST) begin
                  rsp_data_s   = 64'h0;
                  rsp_status_s = ST_OK;
                  lat_cnt_s    = 4'd0;
               end else begin
                  lat_cnt_s = lat_cnt_r + 4'd1;
               end
            end else begin
               lat_cnt_s  = 4'd0;
               poll_cnt_s = '0;
            end
         end
         S_WAIT_RD: begin
            if (lat_cnt_r == RD_LAST) begin
               rsp_data_s   = i_hw_data_out;
               rsp_status_s = ST_OK;
            end else begin
               lat_cnt_s = lat_cnt_r + 4'd1;
            end
         end
         S_POLL: begin
            // Hub completion takes priority over the timeout on the same cycle
            if (i_hw_end_op == END_DONE) begin
               rsp_data_s   = i_hw_data_out;
               rsp_status_s = ST_OK;
            end else if (i_hw_end_op == END_NOMOD) begin
               rsp_data_s   = 64'h0;
               rsp_status_s = ST_NOMOD;
            end else if (poll_done_s) begin
               rsp_data_s   = 64'h0;
               rsp_status_s = ST_TIMEOUT;
            end else begin
               poll_cnt_s = poll_inc_s;
            end
         end
         S_RESP: begin
            if (i_rsp_ready) begin
               hw_control_s = {hw_control_r[63:32], 32'h0};
            end else begin
               hw_control_s = hw_control_r;
            end
         end
         default: begin
            type_s = type_r;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         type_r       <= 2'b00;
         lat_cnt_r    <= 4'd0;
         poll_cnt_r   <= '0;
         rsp_data_r   <= 64'h0;
         rsp_status_r <= 2'b00;
         hw_data_in_r <= 64'h0;
         hw_add_r     <= 64'h0;
         hw_control_r <= 64'h0;
         cmd_ready_r  <= 1'b0;
         rsp_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         type_r       <= type_s;
         lat_cnt_r    <= lat_cnt_s;
         poll_cnt_r   <= poll_cnt_s;
         rsp_data_r   <= rsp_data_s;
         rsp_status_r <= rsp_status_s;
         hw_data_in_r <= hw_data_in_s;
         hw_add_r     <= hw_add_s;
         hw_control_r <= hw_control_s;
         cmd_ready_r  <= (state_s == S_IDLE);
         rsp_valid_r  <= (state_s == S_RESP);
         busy_r       <= (state_s != S_IDLE);
      end
   end

   assign o_cmd_ready  = cmd_ready_r;
   assign o_rsp_valid  = rsp_valid_r;
   assign o_rsp_data   = rsp_data_r;
   assign o_rsp_status = rsp_status_r;
   assign o_hw_data_in = hw_data_in_r;
   assign o_hw_add     = hw_add_r;
   assign o_hw_control = hw_control_r;
   assign o_busy       = busy_r;

`ifdef HWROT_SEQ_STATS_EN
   logic [15:0] stat_cmds_r;
   logic [15:0] stat_tmo_r;
   logic        rsp_fire_s;

   assign rsp_fire_s = (state_r == S_RESP) && i_rsp_ready;

   // Saturating response and timeout counters
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stat_cmds_r <= 16'h0000;
         stat_tmo_r  <= 16'h0000;
      end else begin
         if (rsp_fire_s && (stat_cmds_r != 16'hFFFF)) begin
            stat_cmds_r <= stat_cmds_r + 16'd1;
         end
         if (rsp_fire_s && (rsp_status_r == ST_TIMEOUT) && (stat_tmo_r != 16'hFFFF)) begin
            stat_tmo_r <= stat_tmo_r + 16'd1;
         end
      end
   end

   assign o_stat_cmds = stat_cmds_r;
   assign o_stat_tmo  = stat_tmo_r;
`else
   assign o_stat_cmds = 16'h0000;
   assign o_stat_tmo  = 16'h0000;
`endif

endmodule

// File: tb/tb_hwrot_cmd_sequencer.sv
// Directed self-checking bench for hwrot_cmd_sequencer (TIMEOUT_MAX reduced to 16).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_hwrot_cmd_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic [1:0]  i_cmd_type;
   logic [31:0] i_cmd_module;
   logic [31:0] i_cmd_ctrl;
   logic [63:0] i_cmd_add;
   logic [63:0] i_cmd_data;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [63:0] o_rsp_data;
   logic [1:0]  o_rsp_status;
   logic [63:0] o_hw_data_in;
   logic [63:0] o_hw_add;
   logic [63:0] o_hw_control;
   logic [63:0] i_hw_data_out;
   logic [1:0]  i_hw_end_op;
   logic        o_busy;
   logic [15:0] o_stat_cmds;
   logic [15:0] o_stat_tmo;

   int n_vec = 0;
   int n_err = 0;

`ifdef HWROT_SEQ_STATS_EN
   localparam logic [15:0] EXP_CMDS_AT_TMO = 16'd5;
   localparam logic [15:0] EXP_TMO         = 16'd1;
`else
   localparam logic [15:0] EXP_CMDS_AT_TMO = 16'd0;
   localparam logic [15:0] EXP_TMO         = 16'd0;
`endif

   always #5 i_clk = ~i_clk;

   hwrot_cmd_sequencer #(
      .WR_HOLD     (1),
      .RD_LAT      (2),
      .TIMEOUT_W   (20),
      .TIMEOUT_MAX (20'd16)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_cmd_valid   (i_cmd_valid),
      .o_cmd_ready   (o_cmd_ready),
      .i_cmd_type    (i_cmd_type),
      .i_cmd_module  (i_cmd_module),
      .i_cmd_ctrl    (i_cmd_ctrl),
      .i_cmd_add     (i_cmd_add),
      .i_cmd_data    (i_cmd_data),
      .o_rsp_valid   (o_rsp_valid),
      .i_rsp_ready   (i_rsp_ready),
      .o_rsp_data    (o_rsp_data),
      .o_rsp_status  (o_rsp_status),
      .o_hw_data_in  (o_hw_data_in),
      .o_hw_add      (o_hw_add),
      .o_hw_control  (o_hw_control),
      .i_hw_data_out (i_hw_data_out),
      .i_hw_end_op   (i_hw_end_op),
      .o_busy        (o_busy),
      .o_stat_cmds   (o_stat_cmds),
      .o_stat_tmo    (o_stat_tmo)
   );

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) @(negedge i_clk);
   endtask

   task automatic send(input logic [1:0] t, input logic [31:0] m, input logic [31:0] c,
                       input logic [63:0] a, input logic [63:0] d);
      i_cmd_valid  = 1'b1;
      i_cmd_type   = t;
      i_cmd_module = m;
      i_cmd_ctrl   = c;
      i_cmd_add    = a;
      i_cmd_data   = d;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_type = 2'b00; i_cmd_module = 32'h0; i_cmd_ctrl = 32'h0;
      i_cmd_add = 64'h0; i_cmd_data = 64'h0; i_rsp_ready = 1'b1; i_hw_data_out = 64'h0; i_hw_end_op = 2'b00;
      tick(3);
      n_vec++; if (o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 0", o_cmd_ready); end
      n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", o_rsp_valid); end
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", o_busy); end
      n_vec++; if ({o_hw_control, o_hw_add, o_hw_data_in} !== 192'h0) begin n_err++; $display("FAIL rst_bus: got %h %h %h want 0", o_hw_control, o_hw_add, o_hw_data_in); end
      n_vec++; if ({o_rsp_data, o_rsp_status} !== 66'h0) begin n_err++; $display("FAIL rst_rsp: got %h/%b want 0", o_rsp_data, o_rsp_status); end
      n_vec++; if ({o_stat_cmds, o_stat_tmo} !== 32'h0) begin n_err++; $display("FAIL rst_stats: got %h/%h want 0", o_stat_cmds, o_stat_tmo); end
      i_rst = 1'b0;
      tick(1);
      n_vec++; if (o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", o_cmd_ready); end
   endtask

   task automatic test_read();
      i_hw_data_out = 64'hBAD0_BAD0_BAD0_BAD0;
      send(2'b01, 32'h20, 32'h2, 64'h10, 64'h0);
      tick(1);
      i_cmd_valid = 1'b0;
      n_vec++; if (o_hw_control !== 64'h0000_0020_0000_0002) begin n_err++; $display("FAIL read_control: got %h want 0000002000000002", o_hw_control); end
      n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL read_busy: got %b want 1", o_busy); end
      tick(2);
      n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL read_early_rsp: got %b want 0", o_rsp_valid); end
      i_hw_data_out = 64'h1234;
      tick(1);
      i_hw_data_out = 64'hBAD0_BAD0_BAD0_BAD0;
      n_vec++; if (o_rsp_valid !== 1'b1) begin n_err++; $display("FAIL read_rsp_valid: got %b want 1", o_rsp_valid); end
      n_vec++; if (o_rsp_data !== 64'h1234) begin n_err++; $display("FAIL read_data: got %h want 1234", o_rsp_data); end
      n_vec++; if (o_rsp_status !== 2'b00) begin n_err++; $display("FAIL read_status: got %b want 00", o_rsp_status); end
      tick(1);
   endtask

   task automatic test_write();
      send(2'b00, 32'h30, 32'h1, 64'h5, 64'hDEAD);
      tick(1);
      i_cmd_valid = 1'b0;
      n_vec++; if (o_hw_control !== 64'h0000_0030_0000_0001) begin n_err++; $display("FAIL write_control: got %h want 0000003000000001", o_hw_control); end
      n_vec++; if ({o_hw_add, o_hw_data_in} !== {64'h5, 64'hDEAD}) begin n_err++; $display("FAIL write_add_data: got %h %h want 5 dead", o_hw_add, o_hw_data_in); end
      n_vec++; if (o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL write_ready_issue: got %b want 0", o_cmd_ready); end
      n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL write_rsp_issue: got %b want 0", o_rsp_valid); end
      tick(1);
      n_vec++; if ({o_rsp_valid, o_rsp_status} !== 3'b100) begin n_err++; $display("FAIL write_rsp: got valid %b status %b want 1/00", o_rsp_valid, o_rsp_status); end
      n_vec++; if (o_rsp_data !== 64'h0) begin n_err++; $display("FAIL write_data: got %h want 0", o_rsp_data); end
      tick(1);
      n_vec++; if ({o_rsp_valid, o_cmd_ready, o_busy} !== 3'b010) begin n_err++; $display("FAIL write_idle: got %b want 010", {o_rsp_valid, o_cmd_ready, o_busy}); end
      n_vec++; if (o_hw_control !== 64'h0000_0030_0000_0000) begin n_err++; $display("FAIL write_ctrl_clear: got %h want 0000003000000000", o_hw_control); end
      n_vec++; if (o_hw_add !== 64'h5) begin n_err++; $display("FAIL write_add_hold: got %h want 5", o_hw_add); end
   endtask

   task automatic test_wait_done();
      i_hw_end_op = 2'b00; i_hw_data_out = 64'h5555;
      send(2'b10, 32'h40, 32'h3, 64'h0, 64'h0);
      tick(1);
      i_cmd_valid = 1'b0;
      tick(10);
      n_vec++; if ({o_rsp_valid, o_busy} !== 2'b01) begin n_err++; $display("FAIL wait_polling: got valid %b busy %b want 0/1", o_rsp_valid, o_busy); end
      i_hw_end_op = 2'b01; i_hw_data_out = 64'hABCD;
      tick(1);
      i_hw_end_op = 2'b00; i_hw_data_out = 64'h5555;
      n_vec++; if ({o_rsp_valid, o_rsp_status} !== 3'b100) begin n_err++; $display("FAIL wait_rsp: got valid %b status %b want 1/00", o_rsp_valid, o_rsp_status); end
      n_vec++; if (o_rsp_data !== 64'hABCD) begin n_err++; $display("FAIL wait_data: got %h want abcd", o_rsp_data); end
      tick(1);
   endtask

   task automatic test_wait_nomod();
      i_hw_end_op = 2'b11; i_hw_data_out = 64'h7777;
      send(2'b10, 32'h40, 32'h4, 64'h0, 64'h0);
      tick(1);
      i_cmd_valid = 1'b0;
      n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL nomod_issue_rsp: got %b want 0", o_rsp_valid); end
      tick(2);
      i_hw_end_op = 2'b00;
      n_vec++; if ({o_rsp_valid, o_rsp_status} !== 3'b110) begin n_err++; $display("FAIL nomod_rsp: got valid %b status %b want 1/10", o_rsp_valid, o_rsp_status); end
      n_vec++; if (o_rsp_data !== 64'h0) begin n_err++; $display("FAIL nomod_data: got %h want 0", o_rsp_data); end
      tick(1);
   endtask

   task automatic test_timeout();
      int n_t;
      i_hw_end_op = 2'b00; i_hw_data_out = 64'h9999;
      send(2'b10, 32'h50, 32'h6, 64'h0, 64'h0);
      tick(1);
      i_cmd_valid = 1'b0;
      n_t = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         n_t++;
         if (o_rsp_valid === 1'b1) break;
      end
      n_vec++; if (n_t != 17) begin n_err++; $display("FAIL timeout_latency: got %0d cycles want 17", n_t); end
      n_vec++; if ({o_rsp_valid, o_rsp_status} !== 3'b101) begin n_err++; $display("FAIL timeout_rsp: got valid %b status %b want 1/01", o_rsp_valid, o_rsp_status); end
      n_vec++; if (o_rsp_data !== 64'h0) begin n_err++; $display("FAIL timeout_data: got %h want 0", o_rsp_data); end
      tick(1);
      n_vec++; if (o_stat_tmo !== EXP_TMO) begin n_err++; $display("FAIL stat_tmo: got %0d want %0d", o_stat_tmo, EXP_TMO); end
      n_vec++; if (o_stat_cmds !== EXP_CMDS_AT_TMO) begin n_err++; $display("FAIL stat_cmds: got %0d want %0d", o_stat_cmds, EXP_CMDS_AT_TMO); end
   endtask

   task automatic test_backpressure();
      i_rsp_ready = 1'b0;
      send(2'b00, 32'h60, 32'h5, 64'h0, 64'h1);
      tick(2);
      for (int i = 0; i < 5; i++) begin
         i_cmd_module = 32'h61;
         n_vec++; if ({o_rsp_valid, o_rsp_status, o_cmd_ready} !== 4'b1000) begin n_err++; $display("FAIL bp_hold_%0d: got valid %b status %b ready %b want 1/00/0", i, o_rsp_valid, o_rsp_status, o_cmd_ready); end
         n_vec++; if (o_rsp_data !== 64'h0) begin n_err++; $display("FAIL bp_data_%0d: got %h want 0", i, o_rsp_data); end
         tick(1);
      end
      i_rsp_ready = 1'b1;
      tick(1);
      n_vec++; if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release: got valid %b ready %b want 0/1", o_rsp_valid, o_cmd_ready); end
      n_vec++; if (o_hw_control !== 64'h0000_0060_0000_0000) begin n_err++; $display("FAIL bp_no_accept: got %h want 0000006000000000", o_hw_control); end
      tick(1);
      i_cmd_valid = 1'b0;
      n_vec++; if (o_hw_control !== 64'h0000_0061_0000_0005) begin n_err++; $display("FAIL bp_next_cmd: got %h want 0000006100000005", o_hw_control); end
      tick(2);
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_ctrl;
      for (int k = 0; k < 3; k++) begin
         send(2'b00, 32'hA0 + 32'(k), 32'(k + 1), 64'h100 + 64'(k), 64'h200 + 64'(k));
         exp_ctrl = {32'hA0 + 32'(k), 32'(k + 1)};
         tick(1);
         n_vec++; if (o_hw_control !== exp_ctrl) begin n_err++; $display("FAIL b2b_ctrl_%0d: got %h want %h", k, o_hw_control, exp_ctrl); end
         tick(1);
         n_vec++; if (o_rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rsp_%0d: got %b want 1", k, o_rsp_valid); end
         tick(1);
         n_vec++; if ({o_cmd_ready, o_busy} !== 2'b10) begin n_err++; $display("FAIL b2b_idle_%0d: got ready %b busy %b want 1/0", k, o_cmd_ready, o_busy); end
      end
      i_cmd_valid = 1'b0;
   endtask

   task automatic test_illegal();
      send(2'b11, 32'h99, 32'hFF, 64'h77, 64'h88);
      tick(1);
      i_cmd_valid = 1'b0;
      n_vec++; if ({o_rsp_valid, o_rsp_status} !== 3'b111) begin n_err++; $display("FAIL illegal_rsp: got valid %b status %b want 1/11", o_rsp_valid, o_rsp_status); end
      n_vec++; if (o_rsp_data !== 64'h0) begin n_err++; $display("FAIL illegal_data: got %h want 0", o_rsp_data); end
      n_vec++; if ({o_hw_control, o_hw_add, o_hw_data_in} !== {64'h0000_00A2_0000_0000, 64'h102, 64'h202}) begin n_err++; $display("FAIL illegal_bus: got %h %h %h want 000000a200000000 102 202", o_hw_control, o_hw_add, o_hw_data_in); end
      tick(1);
   endtask

   task automatic test_reset_mid_poll();
      i_hw_end_op = 2'b00;
      send(2'b10, 32'h70, 32'h9, 64'hA, 64'hB);
      tick(1);
      i_cmd_valid = 1'b0;
      tick(2);
      i_rst = 1'b1;
      tick(1);
      n_vec++; if ({o_busy, o_rsp_valid, o_cmd_ready} !== 3'b000) begin n_err++; $display("FAIL mid_rst_state: got %b want 000", {o_busy, o_rsp_valid, o_cmd_ready}); end
      n_vec++; if ({o_hw_control, o_hw_add, o_hw_data_in} !== 192'h0) begin n_err++; $display("FAIL mid_rst_bus: got %h %h %h want 0", o_hw_control, o_hw_add, o_hw_data_in); end
      n_vec++; if ({o_stat_cmds, o_stat_tmo} !== 32'h0) begin n_err++; $display("FAIL mid_rst_stats: got %h/%h want 0", o_stat_cmds, o_stat_tmo); end
      i_rst = 1'b0;
      tick(1);
      n_vec++; if ({o_cmd_ready, o_rsp_valid} !== 2'b10) begin n_err++; $display("FAIL mid_rst_release: got ready %b valid %b want 1/0", o_cmd_ready, o_rsp_valid); end
      tick(3);
      n_vec++; if ({o_rsp_valid, o_busy} !== 2'b00) begin n_err++; $display("FAIL mid_rst_no_rsp: got valid %b busy %b want 0/0", o_rsp_valid, o_busy); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_read();
      test_write();
      test_wait_done();
      test_wait_nomod();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_illegal();
      test_reset_mid_poll();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
